// File: rtl/gpio_pkg.sv
// Shared constants, FSM encodings and payload types for the AXI4-Lite GPIO block.
package gpio_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned REG_OFF_W = 5;

    localparam logic [REG_OFF_W-1:0] OFF_OUT      = 5'h00;
    localparam logic [REG_OFF_W-1:0] OFF_SET      = 5'h04;
    localparam logic [REG_OFF_W-1:0] OFF_CLR      = 5'h08;
    localparam logic [REG_OFF_W-1:0] OFF_IN       = 5'h0C;
    localparam logic [REG_OFF_W-1:0] OFF_IRQ_EN   = 5'h10;
    localparam logic [REG_OFF_W-1:0] OFF_IRQ_STAT = 5'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

    // Expand byte strobes to a per-bit write mask.
    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_gpio_if.sv
// AXI4-Lite bus bundle between the SoC interconnect (master) and the GPIO slave.
interface axi_lite_gpio_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for asynchronous GPIO inputs plus a history flop for rising-edge detect.
module gpio_in_sync #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta;
    logic [W-1:0] prev;

    // Flops reset low so an input already high at reset release reports one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/axi_lite_gpio.sv
// AXI4-Lite GPIO slave: OUT with set/clear aliases, synchronized IN, rising-edge IRQ status.
module axi_lite_gpio
    import gpio_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned GPIO_W    = 32,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    axi_lite_gpio_if.slave    s,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    wr_state_t         wr_state, wr_state_n;
    logic              aw_ready, aw_ready_n;
    logic              w_ready, w_ready_n;
    logic              aw_got, aw_got_n;
    logic              w_got, w_got_n;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_n;
    wbeat_t            wbeat_q, wbeat_n;
    logic              bvalid, bvalid_n;
    logic [1:0]        bresp, bresp_n;

    rd_state_t         rd_state, rd_state_n;
    logic              ar_ready, ar_ready_n;
    logic              rvalid, rvalid_n;
    logic [31:0]       rdata, rdata_n;
    logic [1:0]        rresp, rresp_n;

    logic [GPIO_W-1:0] out_q, out_n;
    logic [GPIO_W-1:0] en_q, en_n;
    logic [GPIO_W-1:0] stat_q, stat_n;
    logic [GPIO_W-1:0] in_sync, in_rise;

    logic                 do_write;
    logic [ADDR_W-1:0]    wr_addr;
    wbeat_t               wr_beat;
    logic [REG_OFF_W-1:0] wr_off, rd_off;
    logic                 wr_upper_ok, rd_upper_ok, wr_err;
    logic [GPIO_W-1:0]    wr_d, wr_m;
    logic                 unused_addr_lsbs;

    gpio_in_sync #(.W(GPIO_W)) u_in_sync (
        .clk   (clk),
        .reset (reset),
        .din   (gpio_in),
        .sync  (in_sync),
        .rise  (in_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state  <= W_IDLE;
            aw_ready  <= 1'b0;
            w_ready   <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            wbeat_q   <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            rd_state  <= R_IDLE;
            ar_ready  <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            out_q     <= GPIO_W'(OUT_RESET);
            en_q      <= '0;
            stat_q    <= '0;
            irq       <= 1'b0;
        end else begin
            wr_state  <= wr_state_n;
            aw_ready  <= aw_ready_n;
            w_ready   <= w_ready_n;
            aw_got    <= aw_got_n;
            w_got     <= w_got_n;
            aw_addr_q <= aw_addr_n;
            wbeat_q   <= wbeat_n;
            bvalid    <= bvalid_n;
            bresp     <= bresp_n;
            rd_state  <= rd_state_n;
            ar_ready  <= ar_ready_n;
            rvalid    <= rvalid_n;
            rdata     <= rdata_n;
            rresp     <= rresp_n;
            out_q     <= out_n;
            en_q      <= en_n;
            stat_q    <= stat_n;
            irq       <= |(stat_q & en_q);
        end
    end

    // Write channel: AW and W captured independently; the update fires when both are held.
    always_comb begin
        wr_state_n = wr_state;
        aw_ready_n = aw_ready;
        w_ready_n  = w_ready;
        aw_got_n   = aw_got;
        w_got_n    = w_got;
        aw_addr_n  = aw_addr_q;
        wbeat_n    = wbeat_q;
        bvalid_n   = bvalid;
        bresp_n    = bresp;
        do_write   = 1'b0;
        wr_addr    = aw_addr_q;
        wr_beat    = wbeat_q;
        case (wr_state)
            W_IDLE: begin
                if (s.awvalid && aw_ready) begin
                    aw_got_n  = 1'b1;
                    aw_addr_n = s.awaddr;
                    wr_addr   = s.awaddr;
                end
                if (s.wvalid && w_ready) begin
                    w_got_n = 1'b1;
                    wbeat_n = '{data: s.wdata, strb: s.wstrb};
                    wr_beat = '{data: s.wdata, strb: s.wstrb};
                end
                if (aw_got_n && w_got_n) begin
                    do_write   = 1'b1;
                    wr_state_n = W_RESP;
                    bvalid_n   = 1'b1;
                    bresp_n    = wr_err ? RESP_SLVERR : RESP_OKAY;
                    aw_got_n   = 1'b0;
                    w_got_n    = 1'b0;
                    aw_ready_n = 1'b0;
                    w_ready_n  = 1'b0;
                end else begin
                    aw_ready_n = !aw_got_n;
                    w_ready_n  = !w_got_n;
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    wr_state_n = W_IDLE;
                    bvalid_n   = 1'b0;
                    aw_ready_n = 1'b1;
                    w_ready_n  = 1'b1;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    assign wr_off      = {wr_addr[4:2], 2'b00};
    assign wr_upper_ok = (wr_addr >> REG_OFF_W) == '0;
    assign wr_err      = !wr_upper_ok || (wr_off > OFF_IRQ_STAT);
    assign wr_d        = GPIO_W'(wr_beat.data);
    assign wr_m        = GPIO_W'(strb_mask(wr_beat.strb));

    // Register file update; a same-cycle input edge overrides a W1C on IRQ_STAT.
    always_comb begin
        out_n  = out_q;
        en_n   = en_q;
        stat_n = stat_q;
        if (do_write && wr_upper_ok) begin
            case (wr_off)
                OFF_OUT:      out_n  = (out_q & ~wr_m) | (wr_d & wr_m);
                OFF_SET:      out_n  = out_q | (wr_d & wr_m);
                OFF_CLR:      out_n  = out_q & ~(wr_d & wr_m);
                OFF_IRQ_EN:   en_n   = (en_q & ~wr_m) | (wr_d & wr_m);
                OFF_IRQ_STAT: stat_n = stat_q & ~(wr_d & wr_m);
                default: ;
            endcase
        end
        stat_n = stat_n | in_rise;
    end

    assign rd_off      = {s.araddr[4:2], 2'b00};
    assign rd_upper_ok = (s.araddr >> REG_OFF_W) == '0;

    // Read channel: data sampled from pre-write register state at the AR handshake.
    always_comb begin
        rd_state_n = rd_state;
        ar_ready_n = ar_ready;
        rvalid_n   = rvalid;
        rdata_n    = rdata;
        rresp_n    = rresp;
        case (rd_state)
            R_IDLE: begin
                ar_ready_n = 1'b1;
                if (s.arvalid && ar_ready) begin
                    rd_state_n = R_DATA;
                    ar_ready_n = 1'b0;
                    rvalid_n   = 1'b1;
                    rdata_n    = '0;
                    rresp_n    = RESP_OKAY;
                    if (!rd_upper_ok) begin
                        rresp_n = RESP_SLVERR;
                    end else begin
                        case (rd_off)
                            OFF_OUT:      rdata_n = 32'(out_q);
                            OFF_SET:      rdata_n = '0;
                            OFF_CLR:      rdata_n = '0;
                            OFF_IN:       rdata_n = 32'(in_sync);
                            OFF_IRQ_EN:   rdata_n = 32'(en_q);
                            OFF_IRQ_STAT: rdata_n = 32'(stat_q);
                            default:      rresp_n = RESP_SLVERR;
                        endcase
                    end
                end
            end
            R_DATA: begin
                if (s.rready) begin
                    rd_state_n = R_IDLE;
                    rvalid_n   = 1'b0;
                    ar_ready_n = 1'b1;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    assign unused_addr_lsbs = ^{wr_addr[1:0], s.araddr[1:0]};

    assign s.awready = aw_ready;
    assign s.wready  = w_ready;
    assign s.bvalid  = bvalid;
    assign s.bresp   = bresp;
    assign s.arready = ar_ready;
    assign s.rvalid  = rvalid;
    assign s.rdata   = rdata;
    assign s.rresp   = rresp;
    assign gpio_out  = out_q;

endmodule

// File: tb/tb_axi_lite_gpio.sv
// Directed bench for axi_lite_gpio with response scoreboards for the B and R channels.
module tb_axi_lite_gpio;
    import gpio_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        irq;

    int vectors = 0;
    int errs    = 0;

    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic [1:0]  exp_bresp_q[$];

    axi_lite_gpio_if #(.ADDR_W(8)) bus ();

    axi_lite_gpio #(.ADDR_W(8), .GPIO_W(32), .OUT_RESET(32'h0)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int gap, input int hold, input logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        logic [1:0] eb;
        exp_bresp_q.push_back(resp);
        @(negedge clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = st;
        if (gap == 0) bus.wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(negedge clk);
            cyc++;
            if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            if (!w_done && !bus.wvalid && cyc >= gap) bus.wvalid = 1'b1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("aw_w_accept", 32'(aw_done && w_done), 32'd1);
        chk("bvalid_latency", 32'(bus.bvalid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
            chk("awready_blocked", 32'(bus.awready), 32'd0);
        end
        eb = exp_bresp_q.pop_front();
        chk("bresp", 32'(bus.bresp), 32'(eb));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input int hold);
        bit done = 0, fire;
        int cyc = 0;
        logic [31:0] ed;
        logic [1:0]  er;
        exp_rdata_q.push_back(d);
        exp_rresp_q.push_back(resp);
        @(negedge clk);
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        while (!done && cyc < 40) begin
            fire = bus.arvalid && bus.arready;
            @(negedge clk);
            cyc++;
            if (fire) begin bus.arvalid = 1'b0; done = 1; end
        end
        bus.arvalid = 1'b0;
        chk("ar_accept", 32'(done), 32'd1);
        chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(bus.rvalid), 32'd1);
            chk("rdata_stable", bus.rdata, exp_rdata_q[0]);
            chk("arready_blocked", 32'(bus.arready), 32'd0);
        end
        ed = exp_rdata_q.pop_front();
        er = exp_rresp_q.pop_front();
        chk("rdata", bus.rdata, ed);
        chk("rresp", 32'(bus.rresp), 32'(er));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [1:0] eb;
        reset       = 1'b1;
        gpio_in     = '0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_awready", 32'(bus.awready), 32'd1);
        chk("rel_wready", 32'(bus.wready), 32'd1);
        chk("rel_arready", 32'(bus.arready), 32'd1);

        // OUT write with W three cycles behind AW, then aliases and byte strobes
        axi_write(8'h00, 32'hDEADBEEF, 4'hF, 3, 0, RESP_OKAY);
        chk("out_full", gpio_out, 32'hDEADBEEF);
        axi_read(8'h00, 32'hDEADBEEF, RESP_OKAY, 0);
        axi_write(8'h04, 32'h000000F0, 4'hF, 0, 0, RESP_OKAY);
        chk("out_set", gpio_out, 32'hDEADBEFF);
        axi_write(8'h08, 32'h0000000F, 4'b0001, 0, 0, RESP_OKAY);
        chk("out_clr", gpio_out, 32'hDEADBEF0);
        axi_write(8'h01, 32'h00001200, 4'b0010, 0, 0, RESP_OKAY);
        chk("out_strb", gpio_out, 32'hDEAD12F0);
        axi_read(8'h04, 32'h0, RESP_OKAY, 0);
        axi_read(8'h08, 32'h0, RESP_OKAY, 0);

        // Concurrent read and write of OUT: read sees the old value
        fork
            axi_write(8'h00, 32'h11111111, 4'hF, 0, 0, RESP_OKAY);
            axi_read(8'h00, 32'hDEAD12F0, RESP_OKAY, 0);
        join
        chk("out_rw_same", gpio_out, 32'h11111111);

        // Back-pressure on both response channels
        axi_read(8'h00, 32'h11111111, RESP_OKAY, 5);
        axi_write(8'h00, 32'h000000A5, 4'hF, 0, 5, RESP_OKAY);
        chk("out_hold", gpio_out, 32'h000000A5);

        // Error and no-effect accesses
        axi_read(8'h18, 32'h0, RESP_SLVERR, 0);
        axi_write(8'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_SLVERR);
        axi_write(8'h80, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_SLVERR);
        axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, RESP_OKAY);
        chk("out_untouched", gpio_out, 32'h000000A5);
        axi_read(8'h80, 32'h0, RESP_SLVERR, 0);
        axi_read(8'h10, 32'h0, RESP_OKAY, 0);

        // Rising edge on gpio_in[3] with IRQ enabled
        axi_write(8'h10, 32'h00000008, 4'hF, 0, 0, RESP_OKAY);
        axi_read(8'h10, 32'h00000008, RESP_OKAY, 0);
        gpio_in = 32'h00000008;
        repeat (3) @(negedge clk);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        axi_read(8'h0C, 32'h00000008, RESP_OKAY, 0);
        axi_read(8'h14, 32'h00000008, RESP_OKAY, 0);
        axi_write(8'h14, 32'h00000008, 4'hF, 0, 0, RESP_OKAY);
        chk("irq_cleared", 32'(irq), 32'd0);
        axi_read(8'h14, 32'h0, RESP_OKAY, 0);

        // W1C landing on the same edge as a fresh input event: event survives
        gpio_in = 32'h0;
        repeat (4) @(negedge clk);
        gpio_in = 32'h00000008;
        repeat (2) @(negedge clk);
        exp_bresp_q.push_back(RESP_OKAY);
        bus.awvalid = 1'b1; bus.awaddr = 8'h14;
        bus.wvalid  = 1'b1; bus.wdata  = 32'h8; bus.wstrb = 4'hF;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("coinc_bvalid", 32'(bus.bvalid), 32'd1);
        eb = exp_bresp_q.pop_front();
        chk("coinc_bresp", 32'(bus.bresp), 32'(eb));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        axi_read(8'h14, 32'h00000008, RESP_OKAY, 0);
        chk("coinc_irq", 32'(irq), 32'd1);

        // Reset while a write response is pending
        bus.awvalid = 1'b1; bus.awaddr = 8'h00;
        bus.wvalid  = 1'b1; bus.wdata  = 32'h55; bus.wstrb = 4'hF;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("mid_bvalid", 32'(bus.bvalid), 32'd1);
        chk("mid_out", gpio_out, 32'h55);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("mid_rst_out", gpio_out, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rel_awready", 32'(bus.awready), 32'd1);
        chk("mid_rel_arready", 32'(bus.arready), 32'd1);
        repeat (4) @(negedge clk);
        axi_read(8'h10, 32'h0, RESP_OKAY, 0);
        axi_read(8'h14, 32'h00000008, RESP_OKAY, 0);

        chk("sb_empty", 32'(exp_rdata_q.size() + exp_rresp_q.size() + exp_bresp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/axi_lite_gpio.md
# axi_lite_gpio

AXI4-Lite slave GPIO peripheral that produces the SoC's `gpio_out` bus; it sits directly downstream of the PicoRV32 AXI master (via the `soc_top` interconnect) and is the stage that firmware writes to drive `gpio_out`. It adds set/clear aliases, a synchronized input port with rising-edge capture, and a level interrupt. Single outstanding transaction per channel; no bursts.

## Interface
- `ADDR_W`, 8: byte-address width decoded (registers in low 5 bits; upper bits must be 0 or access errors).
- `GPIO_W`, 32: GPIO width (1..32); unused data bits read 0, writes ignored.
- `OUT_RESET`, 32'h0: reset value of `gpio_out`.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `s_awvalid`/`s_awready` in/out 1, `s_awaddr` in ADDR_W: write address.
- `s_wvalid`/`s_wready` in/out 1, `s_wdata` in 32, `s_wstrb` in 4: write data.
- `s_bvalid`/`s_bready` out/in 1, `s_bresp` out 2: write response.
- `s_arvalid`/`s_arready` in/out 1, `s_araddr` in ADDR_W: read address.
- `s_rvalid`/`s_rready` out/in 1, `s_rdata` out 32, `s_rresp` out 2: read data.
- `gpio_in` in GPIO_W: asynchronous external inputs.
- `gpio_out` out GPIO_W: registered output bus.
- `irq` out 1: level interrupt, `|(IRQ_STAT & IRQ_EN)`, registered.

## Operation
- Register map (byte offsets): 0x00 OUT (RW); 0x04 SET (WO, write-1-sets OUT bits, reads 0); 0x08 CLR (WO, write-1-clears OUT, reads 0); 0x0C IN (RO, synchronized inputs); 0x10 IRQ_EN (RW); 0x14 IRQ_STAT (RW1C, set on synchronized rising edge of each input).
- Byte strobes apply to OUT, SET, CLR, IRQ_EN, IRQ_STAT; strobe-off bytes unchanged. Non-word-aligned low bits (addr[1:0]) ignored.
- Unmapped offset (0x18..0x1F or nonzero upper bits): write has no effect, read returns 0; response SLVERR (2'b10). Write to IN: no effect, OKAY.
- Write FSM: W_IDLE -> captures AW and W independently (either order, or same cycle); each ready is high only until its beat is taken. When both held -> W_RESP: register update in the entry cycle, `s_bvalid`=1 held until `s_bready`; then W_IDLE.
- Read FSM: R_IDLE, `s_arready`=1; on AR handshake -> R_DATA, `s_rdata`/`s_rresp` registered, `s_rvalid` held until `s_rready`; `s_arready`=0 while in R_DATA.
- Same-cycle edge event and W1C on same IRQ_STAT bit: set wins (event not lost).
- Read and write to same register in same cycle: read returns pre-write value.
- Input path: 2-flop synchronizer then 1 flop for edge detect; rising edge = sync & ~prev.

## Timing
- Reset: `gpio_out`=OUT_RESET, IRQ_EN=0, IRQ_STAT=0, `irq`=0, all valids/readys 0 during reset; `s_awready`,`s_wready`,`s_arready`=1 first cycle after reset deasserts. Synchronizer flops reset to 0 (a high input at reset release produces one edge event).
- Write latency: AW+W both accepted in cycle N -> `gpio_out` and `s_bvalid` update at edge ending N+1... specifically visible in cycle N+1.
- Read latency: AR accepted in cycle N -> `s_rvalid`=1 in N+1.
- `gpio_in` change -> IN readable after 2 cycles; IRQ_STAT set after 3; `irq` after 4.
- Reset mid-transaction: transaction dropped, no response issued, FSMs to idle.

## Structure
- Package `gpio_pkg`: register offset localparams (OFF_OUT..OFF_IRQ_STAT), RESP_OKAY/RESP_SLVERR, FSM state encodings.
- Sub-module `gpio_in_sync`: per-bit 2-flop synchronizer plus edge-detect flop, outputs `sync` and `rise` vectors.
- Top integrates into `soc_top` so `gpio_out` drives the existing SoC port.

## Test plan
- Reset release -> `gpio_out`=0, `irq`=0, `s_awready`=`s_wready`=`s_arready`=1.
- Write 0x00=0xDEADBEEF, strobe 4'hF, then W issued 3 cycles after AW -> `gpio_out`=DEADBEEF one cycle after W beat, `s_bresp`=0; read 0x00 returns DEADBEEF.
- SET 0x04=0x000000F0 then CLR 0x08=0x0000000F, strobe 4'b0001 only on second -> `gpio_out`=0xDEADBEF0; byte-strobe 4'b0010 write to 0x00 of 0x00001200 -> only bits[15:8] become 0x12.
- `gpio_in[3]` 0->1 with IRQ_EN=0x8 -> IRQ_STAT=0x8 after 3 cycles, `irq`=1 after 4; write 0x14=0x8 -> `irq`=0; repeat with W1C coincident with new edge -> bit stays 1.
- Read 0x18 and write 0x1C -> `s_rresp`=`s_bresp`=2'b10, `s_rdata`=0, no register changes.
- Hold `s_bready`/`s_rready` low 5 cycles -> valids stay high, data stable, no new AW/AR accepted; assert `reset` while `s_bvalid`=1 -> `s_bvalid`=0 next cycle, `gpio_out`=OUT_RESET.
